// File: rtl/memctl_sb.sv
// -----------------------------------------------------------------------------
// memctl_sb : data-memory controller with a posted-store buffer
//
// This block sits between the MM pipeline stage and the data bus. It does the
// following:
//   - accepts requests through a valid/ready handshake;
//   - rejects misaligned half/word accesses without touching the bus;
//   - posts aligned stores into a small FIFO;
//   - issues a load only once every buffered store has drained, so stores
//     stay ordered before the load;
//   - waits for dbus_ok with an optional timeout;
//   - extracts the addressed byte or half from the load data and
//     sign- or zero-extends it.
//
// Parameters:
//   ADDR_W    byte address width
//   SB_DEPTH  store-buffer entries (power of two, >= 2)
//   TIMEOUT   max dbus_en cycles without dbus_ok before abort; 0 = no timeout
//   W_OPER    width of the operation code; OPER_* give the memory op encodings
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (accept on valid & ready)
//   oper, req_addr, req_data operation, byte address, right-aligned store data
//   resp_valid/data/err      one-cycle response (err 00 ok, 01 misaligned,
//                            10 bus timeout)
//   dbus_en/we/size/addr/    registered bus request; size 00 byte, 01 half,
//   dbus_data/strb           10 word; write data is lane-replicated
//   dbus_ok, dbus_rdata      transfer complete / read data, sampled on clk
//   sb_empty                 no store buffered or in flight
//   sb_err                   one-cycle pulse when a buffered store times out
// -----------------------------------------------------------------------------
module memctl_sb #(
    parameter int                ADDR_W    = 32,
    parameter int                SB_DEPTH  = 4,
    parameter int                TIMEOUT   = 255,
    parameter int                W_OPER    = 4,
    parameter logic [W_OPER-1:0] OPER_LB   = W_OPER'(1),
    parameter logic [W_OPER-1:0] OPER_LBU  = W_OPER'(2),
    parameter logic [W_OPER-1:0] OPER_LH   = W_OPER'(3),
    parameter logic [W_OPER-1:0] OPER_LHU  = W_OPER'(4),
    parameter logic [W_OPER-1:0] OPER_LW   = W_OPER'(5),
    parameter logic [W_OPER-1:0] OPER_SB   = W_OPER'(6),
    parameter logic [W_OPER-1:0] OPER_SH   = W_OPER'(7),
    parameter logic [W_OPER-1:0] OPER_SW   = W_OPER'(8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_OPER-1:0] oper,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_err,
    output logic              dbus_en,
    output logic              dbus_we,
    output logic [1:0]        dbus_size,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [31:0]       dbus_data,
    output logic [3:0]        dbus_strb,
    input  logic              dbus_ok,
    input  logic [31:0]       dbus_rdata,
    output logic              sb_empty,
    output logic              sb_err
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // The counter only needs to reach TIMEOUT-1: the abort fires on the
    // cycle that would take it to TIMEOUT.
    localparam int WC_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit                TO_EN     = (TIMEOUT != 0);
    localparam logic [WC_W-1:0]   WAIT_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0]  SB_FULL   = CNT_W'(SB_DEPTH);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_TO  = 2'b10;

    typedef enum logic [1:0] {
        B_IDLE  = 2'd0,
        B_STORE = 2'd1,
        B_LOAD  = 2'd2
    } bstate_t;

    // Byte-lane enables for an access of the given size at the given offset.
    function automatic logic [3:0] lane_strobe(input logic [1:0] size,
                                               input logic [1:0] ofs);
        logic [3:0] s;
        case (size)
            SZ_B:    s = 4'b0001 << ofs;
            SZ_H:    s = ofs[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Pick the addressed lane(s) out of the bus word and extend to 32 bits.
    function automatic logic [31:0] extract(input logic [31:0] rd,
                                            input logic [1:0]  size,
                                            input logic [1:0]  ofs,
                                            input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{ofs, 3'b000} +: 8];
        h = ofs[1] ? rd[31:16] : rd[15:0];
        case (size)
            SZ_B:    r = {{24{sgn & b[7]}}, b};
            SZ_H:    r = {{16{sgn & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    // ---------------- state ----------------
    bstate_t             state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic                load_pending_q, load_pending_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [1:0]          ld_size_q, ld_size_d;
    logic                ld_signed_q, ld_signed_d;
    logic                ready_q, ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [1:0]          resp_err_q, resp_err_d;
    logic                sb_err_q, sb_err_d;
    logic                dbus_en_q, dbus_en_d;
    logic                dbus_we_q, dbus_we_d;
    logic [1:0]          dbus_size_q, dbus_size_d;
    logic [ADDR_W-1:0]   dbus_addr_q, dbus_addr_d;
    logic [31:0]         dbus_data_q, dbus_data_d;
    logic [3:0]          dbus_strb_q, dbus_strb_d;

    // Store buffer storage (no reset needed: validity is tracked by count_q).
    logic [ADDR_W-1:0]   sb_addr_mem [SB_DEPTH];
    logic [1:0]          sb_size_mem [SB_DEPTH];
    logic [31:0]         sb_data_mem [SB_DEPTH];
    logic [3:0]          sb_strb_mem [SB_DEPTH];

    // ---------------- request decode ----------------
    logic        is_load, is_store, req_signed, misaligned;
    logic        accept, push, pop, ld_start, ld_done, timeout_hit;
    logic [1:0]  req_size;
    logic [31:0] push_data;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        req_signed = 1'b0;
        req_size   = SZ_B;
        case (oper)
            OPER_LB:  begin is_load  = 1'b1; req_size = SZ_B; req_signed = 1'b1; end
            OPER_LBU: begin is_load  = 1'b1; req_size = SZ_B; end
            OPER_LH:  begin is_load  = 1'b1; req_size = SZ_H; req_signed = 1'b1; end
            OPER_LHU: begin is_load  = 1'b1; req_size = SZ_H; end
            OPER_LW:  begin is_load  = 1'b1; req_size = SZ_W; end
            OPER_SB:  begin is_store = 1'b1; req_size = SZ_B; end
            OPER_SH:  begin is_store = 1'b1; req_size = SZ_H; end
            OPER_SW:  begin is_store = 1'b1; req_size = SZ_W; end
            default:  ;
        endcase

        misaligned = (is_load | is_store) &
                     (((req_size == SZ_H) & req_addr[0]) |
                      ((req_size == SZ_W) & (req_addr[1:0] != 2'b00)));

        // Non-memory opcodes are accepted but fall through every qualifier.
        accept   = req_valid & ready_q;
        push     = accept & is_store & ~misaligned;
        ld_start = accept & is_load  & ~misaligned;

        case (req_size)
            SZ_B:    push_data = {4{req_data[7:0]}};
            SZ_H:    push_data = {2{req_data[15:0]}};
            default: push_data = req_data;
        endcase
    end

    // ---------------- bus FSM, next-state and outputs ----------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dbus_en_d    = dbus_en_q;
        dbus_we_d    = dbus_we_q;
        dbus_size_d  = dbus_size_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_data_d  = dbus_data_q;
        dbus_strb_d  = dbus_strb_q;
        pop          = 1'b0;
        ld_done      = 1'b0;
        sb_err_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_data_d  = 32'h0;
        resp_err_d   = ERR_OK;
        timeout_hit  = TO_EN && !dbus_ok && (wait_cnt_q == WAIT_LAST);

        case (state_q)
            B_IDLE: begin
                // Buffered stores always drain before a pending load issues.
                if (count_q != '0) begin
                    state_d     = B_STORE;
                    wait_cnt_d  = '0;
                    dbus_en_d   = 1'b1;
                    dbus_we_d   = 1'b1;
                    dbus_size_d = sb_size_mem[rd_ptr_q];
                    dbus_addr_d = sb_addr_mem[rd_ptr_q];
                    dbus_data_d = sb_data_mem[rd_ptr_q];
                    dbus_strb_d = sb_strb_mem[rd_ptr_q];
                end else if (load_pending_q) begin
                    state_d     = B_LOAD;
                    wait_cnt_d  = '0;
                    dbus_en_d   = 1'b1;
                    dbus_we_d   = 1'b0;
                    dbus_size_d = ld_size_q;
                    dbus_addr_d = ld_addr_q;
                    dbus_data_d = 32'h0;
                    dbus_strb_d = lane_strobe(ld_size_q, ld_addr_q[1:0]);
                end
            end
            B_STORE, B_LOAD: begin
                if (dbus_ok || timeout_hit) begin
                    state_d     = B_IDLE;
                    dbus_en_d   = 1'b0;
                    dbus_we_d   = 1'b0;
                    dbus_size_d = 2'b00;
                    dbus_addr_d = '0;
                    dbus_data_d = 32'h0;
                    dbus_strb_d = 4'h0;
                    if (state_q == B_STORE) begin
                        // A timed-out store is dropped, never retried.
                        pop      = 1'b1;
                        sb_err_d = timeout_hit;
                    end else begin
                        ld_done      = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_err_d   = dbus_ok ? ERR_OK : ERR_TO;
                        resp_data_d  = dbus_ok ? extract(dbus_rdata, ld_size_q,
                                                         ld_addr_q[1:0], ld_signed_q)
                                               : 32'h0;
                    end
                end else if (TO_EN) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end
            end
            default: state_d = B_IDLE;
        endcase

        // Request-side responses; load_pending_q blocks acceptance, so these
        // never collide with a load completion.
        if (accept & misaligned) begin
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_MIS;
            resp_data_d  = 32'(req_addr);
        end else if (push) begin
            resp_valid_d = 1'b1;
            resp_err_d   = ERR_OK;
            resp_data_d  = 32'h0;
        end
    end

    // ---------------- bookkeeping next-state ----------------
    always_comb begin
        wr_ptr_d       = wr_ptr_q + PTR_W'(push);
        rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        load_pending_d = ld_start ? 1'b1 : (ld_done ? 1'b0 : load_pending_q);
        ld_addr_d      = ld_start ? req_addr   : ld_addr_q;
        ld_size_d      = ld_start ? req_size   : ld_size_q;
        ld_signed_d    = ld_start ? req_signed : ld_signed_q;
        // Registered so req_ready is low while reset is held; the value is
        // purely a function of the next registered state.
        ready_d        = !load_pending_d && (count_d != SB_FULL);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr_mem[wr_ptr_q] <= req_addr;
            sb_size_mem[wr_ptr_q] <= req_size;
            sb_data_mem[wr_ptr_q] <= push_data;
            sb_strb_mem[wr_ptr_q] <= lane_strobe(req_size, req_addr[1:0]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= B_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            wait_cnt_q     <= '0;
            load_pending_q <= 1'b0;
            ld_addr_q      <= '0;
            ld_size_q      <= 2'b00;
            ld_signed_q    <= 1'b0;
            ready_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 32'h0;
            resp_err_q     <= 2'b00;
            sb_err_q       <= 1'b0;
            dbus_en_q      <= 1'b0;
            dbus_we_q      <= 1'b0;
            dbus_size_q    <= 2'b00;
            dbus_addr_q    <= '0;
            dbus_data_q    <= 32'h0;
            dbus_strb_q    <= 4'h0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            wait_cnt_q     <= wait_cnt_d;
            load_pending_q <= load_pending_d;
            ld_addr_q      <= ld_addr_d;
            ld_size_q      <= ld_size_d;
            ld_signed_q    <= ld_signed_d;
            ready_q        <= ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            sb_err_q       <= sb_err_d;
            dbus_en_q      <= dbus_en_d;
            dbus_we_q      <= dbus_we_d;
            dbus_size_q    <= dbus_size_d;
            dbus_addr_q    <= dbus_addr_d;
            dbus_data_q    <= dbus_data_d;
            dbus_strb_q    <= dbus_strb_d;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign dbus_en    = dbus_en_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_size  = dbus_size_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_data  = dbus_data_q;
    assign dbus_strb  = dbus_strb_q;
    // A store stays in the FIFO until its bus transfer ends, so an empty
    // count also means nothing is on the bus.
    assign sb_empty   = (count_q == '0);
    assign sb_err     = sb_err_q;

endmodule

// File: doc/memctl_sb.md
# memctl_sb

Parametrised data-memory controller between the MM pipeline stage and the data bus. It adds to plain combinational bus mapping:
- a request/ready handshake;
- misalignment detection;
- a posted-store buffer;
- a bus-ack wait with timeout;
- load-data lane extraction with sign or zero extension.

It returns one registered response per accepted load, store or misaligned access.

## Interface
- `ADDR_W`, 32, address width.
- `SB_DEPTH`, 4, store-buffer entries; power of two, ≥2.
- `TIMEOUT`, 255, max cycles waiting for `dbus_ok` before abort; 0 disables the timeout.

Ports (data is fixed at 32 bits, 4 byte lanes, little-endian):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on the edge where `req_valid & req_ready`.
- `oper` in `W_OPER`: codebase operation code; only `OPER_LB/LBU/LH/LHU/LW/SB/SH/SW` are memory ops.
- `req_addr` in `ADDR_W`: byte address.
- `req_data` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse; no backpressure.
- `resp_data` out 32: load result; bad address on misalignment; 0 otherwise.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 bus timeout.
- `dbus_en` out 1: bus request.
- `dbus_we` out 1: write.
- `dbus_size` out 2: 00 byte, 01 half, 10 word.
- `dbus_addr` out `ADDR_W`.
- `dbus_data` out 32: write data, lane-replicated.
- `dbus_strb` out 4: byte-lane enables.
- `dbus_ok` in 1: transfer complete; sampled at the clock edge.
- `dbus_rdata` in 32: read data, valid with `dbus_ok`.
- `sb_empty` out 1: store buffer empty and no store on the bus.
- `sb_err` out 1: one-cycle pulse when a buffered store times out.

## Operation
- `req_ready` = `!load_pending & (sb_count != SB_DEPTH)`. It depends only on registered state, never on `oper`.
- Accepted non-memory `oper`: discarded; no response, no state change.

Misalignment check:
- Half with `addr[0]`=1, or word with `addr[1:0]`≠0, is misaligned.
- Effect: no bus access; response `err`=01, `data`=`req_addr` (zero-extended to 32).

Aligned store:
- Pushed into the FIFO as addr, size, replicated data, strobe.
- Immediate response: `err`=00, `data`=0.
- Replication: byte → {4{b}}, half → {2{h}}, word as is.
- Strobe: byte → 1<<`addr[1:0]`; half → `addr[1]` ? 1100 : 0011; word → 1111.

Aligned load:
- Sets `load_pending`.
- Issued only when the FIFO is empty and the bus is idle, so stores are ordered before the load.

Bus FSM:
- States: `B_IDLE`, `B_STORE`, `B_LOAD`.
- `B_IDLE` → `B_STORE` if the FIFO is non-empty (head has priority).
- `B_IDLE` → `B_LOAD` if `load_pending` and the FIFO is empty.
- `B_STORE`/`B_LOAD` → `B_IDLE` on `dbus_ok` or timeout.
- All `dbus_*` outputs are registered and held stable while `dbus_en`=1. In `B_LOAD`, `dbus_strb` = lanes read and `dbus_data` = 0.
- Store completion: FIFO pop.
- Load completion: response with extracted data; `load_pending` cleared.

Load extraction:
- Byte lane = `addr[1:0]`; half = `addr[1]` ? [31:16] : [15:0].
- LB/LH sign-extend; LBU/LHU zero-extend.

Timeout:
- `wait_cnt` counts cycles with `dbus_en`=1 and `dbus_ok`=0.
- When it reaches `TIMEOUT`: `dbus_en` drops next cycle.
  - Load: response `err`=10, `data`=0.
  - Store: entry popped and dropped, `sb_err` pulses.
- `wait_cnt` clears at every transaction start.

## Timing
- Reset: all outputs 0 except `sb_empty`=1; FIFO pointers, count, `wait_cnt`, `load_pending` cleared; FSM to `B_IDLE`.
- Reset mid-transaction: the in-flight access and all buffered stores are discarded without a response.
- Store or misaligned response: `resp_valid` exactly 1 cycle after the acceptance edge.
- Bus start: `dbus_en` rises at the earliest 1 cycle after the enabling condition is registered, i.e. the push edge or pending-load edge.
- `dbus_ok` high at edge N:
  - `dbus_en` low from cycle N+1.
  - Load: `resp_valid` and `resp_data` in cycle N+1.
  - Next transaction: `dbus_en` high at earliest in N+2; at least one idle cycle between transactions.
- `dbus_ok` while `dbus_en`=0 is ignored.
- Push and pop in the same edge: count unchanged. Full FIFO keeps `req_ready`=0 during that edge; no bypass.
- At most one response per cycle. A misaligned/store response and a load response cannot coincide, because `load_pending` blocks new requests.
- FIFO pointers are `log2(SB_DEPTH)` bits and wrap naturally.

## Test plan
- Reset, then SW addr 0x100 data 0x11223344 with `dbus_ok` one cycle after `dbus_en` → response err 00 next cycle; bus shows we=1, size 10, strb 1111, data 0x11223344; `sb_empty` returns 1.
- SB addr 0x103 data 0xA5 → strb 1000, `dbus_data` 0xA5A5A5A5. Then LB addr 0x103 with rdata 0x80xxxxxx → `resp_data` 0xFFFFFF80; LBU → 0x00000080.
- LH addr 0x201 → err 01, data 0x201, no `dbus_en`. LW addr 0x202 → err 01.
- Hold `dbus_ok`=0: SB_DEPTH+1 stores → `req_ready` low after the 4th accept. Then issue LW; it issues only after all stores pop, in order.
- TIMEOUT=3, load with `dbus_ok` never asserted → `dbus_en` high 3 cycles, then response err 10.
- Assert `rst` while `dbus_en`=1 with 2 stores buffered → all outputs 0 immediately, `sb_empty`=1, no response.
